// File: rtl/vga_shadow_ram_if.sv
// Write-bus definitions for vga_shadow_ram.
//
// vga_shadow_ram_pkg : mem_op_t store-size encoding. MEM_BYTE and
//                      MEM_HALF_WORD select 1 and 2 bytes; every other
//                      encoding is a full 32-bit word.
// vga_shadow_ram_if  : NUM_CH independent write channels, packed per channel.
//   wr_valid [NUM_CH]          per-channel write request   (master -> slave)
//   wr_ready [NUM_CH]          per-channel write accept    (slave -> master)
//   wr_op    [NUM_CH]          store size, mem_op_t        (master -> slave)
//   wr_addr  [NUM_CH*ADDR_W]   byte address, ch c at [c*ADDR_W +: ADDR_W]
//   wr_data  [NUM_CH*32]       LSB-aligned store data, ch c at [c*32 +: 32]
package vga_shadow_ram_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE      = 2'd0,
    MEM_HALF_WORD = 2'd1,
    MEM_WORD      = 2'd2,
    MEM_WORD_ALT  = 2'd3
  } mem_op_t;
endpackage

interface vga_shadow_ram_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8
);
  import vga_shadow_ram_pkg::*;

  logic [NUM_CH-1:0]        wr_valid;
  logic [NUM_CH-1:0]        wr_ready;
  mem_op_t [NUM_CH-1:0]     wr_op;
  logic [NUM_CH*ADDR_W-1:0] wr_addr;
  logic [NUM_CH*32-1:0]     wr_data;

  modport master (output wr_valid, wr_op, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_op, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/vga_shadow_ram.sv
// Shadow memory feeding the VGA debug display.
//
// NUM_CH byte-addressable banks of DEPTH 32-bit words, one per write channel.
// Byte, half-word and word stores; a store that crosses a word boundary is
// written as two beats (lanes off..3 of word, then the rest of word+1,
// wrapping modulo DEPTH). One registered read port returns word rd_addr_i of
// every bank, read-first against same-cycle writes.
//
// Optional feature: define VGA_RAM_CLEAR_EN to zero every bank with a
// DEPTH-cycle sweep after reset (clear_busy_o high, writes held off).
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   bus           vga_shadow_ram_if.slave write channels
//   rd_addr_i     display word address
//   rd_data_o     bank c word at [c*32 +: 32], one-cycle latency
//   clear_busy_o  high while the post-reset clear sweep runs
module vga_shadow_ram
  import vga_shadow_ram_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  vga_shadow_ram_if.slave          bus,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [NUM_CH*32-1:0]     rd_data_o,
  output logic                     clear_busy_o
);

  localparam int WORD_W = $clog2(DEPTH);
  localparam int ADDR_W = WORD_W + 2;

`ifdef VGA_RAM_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SPLIT, ST_CLEAR} state_t;
  localparam state_t               RST_STATE = ST_CLEAR;
  localparam logic                 RST_READY = 1'b0;
  localparam logic [WORD_W-1:0]    LAST_WORD = WORD_W'(DEPTH - 1);
  logic [WORD_W-1:0]               clr_cnt_q;
  logic                            busy_q;
`else
  typedef enum logic {ST_IDLE, ST_SPLIT} state_t;
  localparam state_t               RST_STATE = ST_IDLE;
  localparam logic                 RST_READY = 1'b1;
`endif

  logic [31:0]       mem_q        [NUM_CH][DEPTH];
  state_t            state_q      [NUM_CH];
  logic [NUM_CH-1:0] ready_q;
  logic [31:0]       rd_data_q    [NUM_CH];
  logic [31:0]       spill_data_q [NUM_CH];
  logic [3:0]        spill_be_q   [NUM_CH];
  logic [WORD_W-1:0] spill_word_q [NUM_CH];

  // Store decode: an 8-lane window spanning word and word+1. Lanes 0..3 are
  // beat 1, lanes 4..7 are the spill that a crossing store leaves for SPLIT.
  logic [7:0]        be_w   [NUM_CH];
  logic [63:0]       sh_w   [NUM_CH];
  logic [WORD_W-1:0] word_w [NUM_CH];
  logic [WORD_W-1:0] nxt_w  [NUM_CH];

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [7:0]        mask;
    for (int c = 0; c < NUM_CH; c++) begin
      a    = bus.wr_addr[c*ADDR_W +: ADDR_W];
      case (bus.wr_op[c])
        MEM_BYTE:      mask = 8'h01;
        MEM_HALF_WORD: mask = 8'h03;
        default:       mask = 8'h0F;
      endcase
      be_w[c]   = mask << a[1:0];
      sh_w[c]   = {32'd0, bus.wr_data[c*32 +: 32]} << {a[1:0], 3'b000};
      word_w[c] = a[ADDR_W-1:2];
      // Power-of-two depth: natural overflow gives the modulo-DEPTH wrap.
      nxt_w[c]  = a[ADDR_W-1:2] + WORD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]   <= RST_STATE;
        rd_data_q[c] <= '0;
      end
      ready_q <= {NUM_CH{RST_READY}};
`ifdef VGA_RAM_CLEAR_EN
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
`endif
    end else begin
      // Read port samples before this edge's writes land: read-first.
      for (int c = 0; c < NUM_CH; c++) begin
        rd_data_q[c] <= mem_q[c][rd_addr_i];
      end

`ifdef VGA_RAM_CLEAR_EN
      if (busy_q) begin
        for (int c = 0; c < NUM_CH; c++) begin
          mem_q[c][clr_cnt_q] <= '0;
        end
        clr_cnt_q <= clr_cnt_q + WORD_W'(1);
        if (clr_cnt_q == LAST_WORD) begin
          busy_q <= 1'b0;
        end
      end
`endif

      for (int c = 0; c < NUM_CH; c++) begin
        case (state_q[c])
          ST_IDLE: begin
            if (bus.wr_valid[c] && ready_q[c]) begin
              for (int b = 0; b < 4; b++) begin
                if (be_w[c][b]) begin
                  mem_q[c][word_w[c]][b*8 +: 8] <= sh_w[c][b*8 +: 8];
                end
              end
              if (|be_w[c][7:4]) begin
                spill_be_q[c]   <= be_w[c][7:4];
                spill_data_q[c] <= sh_w[c][63:32];
                spill_word_q[c] <= nxt_w[c];
                state_q[c]      <= ST_SPLIT;
                ready_q[c]      <= 1'b0;
              end
            end
          end
          ST_SPLIT: begin
            for (int b = 0; b < 4; b++) begin
              if (spill_be_q[c][b]) begin
                mem_q[c][spill_word_q[c]][b*8 +: 8] <= spill_data_q[c][b*8 +: 8];
              end
            end
            state_q[c] <= ST_IDLE;
            ready_q[c] <= 1'b1;
          end
`ifdef VGA_RAM_CLEAR_EN
          ST_CLEAR: begin
            if (busy_q && clr_cnt_q == LAST_WORD) begin
              state_q[c] <= ST_IDLE;
              ready_q[c] <= 1'b1;
            end
          end
`endif
          default: begin
            state_q[c] <= ST_IDLE;
            ready_q[c] <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.wr_ready = ready_q;

  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_data_o[c*32 +: 32] = rd_data_q[c];
    end
  end

`ifdef VGA_RAM_CLEAR_EN
  assign clear_busy_o = busy_q;
`else
  assign clear_busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_shadow_ram.sv
// Self-checking bench for vga_shadow_ram (NUM_CH=4, DEPTH=64).
// Reference model: a flat 256-byte array per channel; a store of size n at
// byte address a writes bytes a..a+n-1 modulo 256, which covers lane
// selection, word splitting and wrap-around in one rule.
module tb_vga_shadow_ram;
  import vga_shadow_ram_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [5:0]           rd_addr = '0;
  logic [NUM_CH*32-1:0] rd_data;
  logic                 clear_busy;

  vga_shadow_ram_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  vga_shadow_ram #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .clear_busy_o (clear_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [NUM_CH][256];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int op_size(logic [1:0] op);
    return (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit crosses(logic [1:0] op, logic [7:0] addr);
    return (int'(addr[1:0]) + op_size(op)) > 4;
  endfunction

  task automatic model_store(int c, logic [1:0] op, logic [7:0] addr, logic [31:0] data);
    for (int i = 0; i < op_size(op); i++) begin
      ref_mem[c][8'(int'(addr) + i)] = data[i*8 +: 8];
    end
  endtask

  function automatic logic [31:0] ref_word(int c, int w);
    return {ref_mem[c][4*w+3], ref_mem[c][4*w+2], ref_mem[c][4*w+1], ref_mem[c][4*w]};
  endfunction

  task automatic wait_ready(int c);
    int n = 0;
    while (bus.wr_ready[c] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus.wr_ready[c] !== 1'b1) begin
      n_chk++;
      $display("FAIL wait_ready ch%0d: wr_ready=%b required 1 within 200 cycles", c, bus.wr_ready[c]);
    end
  endtask

  task automatic do_write(int c, logic [1:0] op, logic [7:0] addr, logic [31:0] data);
    wait_ready(c);
    bus.wr_valid[c] = 1'b1;
    bus.wr_op[c]    = mem_op_t'(op);
    bus.wr_addr[c*ADDR_W +: ADDR_W] = addr;
    bus.wr_data[c*32 +: 32] = data;
    tick();
    bus.wr_valid[c] = 1'b0;
    model_store(c, op, addr, data);
  endtask

  // Two edges: the first lets any pending spill commit, the second reads.
  task automatic read_word(int w);
    rd_addr = 6'(w);
    tick();
    tick();
  endtask

  task automatic check_all(string name);
    for (int w = 0; w < DEPTH; w++) begin
      rd_addr = 6'(w);
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        n_chk++;
        if (rd_data[c*32 +: 32] !== ref_word(c, w))
          $display("FAIL %s ch%0d word%0d: got %h required %h", name, c, w, rd_data[c*32 +: 32], ref_word(c, w));
        else n_pass++;
      end
    end
  endtask

  task automatic prefill();
    for (int w = 0; w < DEPTH; w++) begin
      for (int c = 0; c < NUM_CH; c++) wait_ready(c);
      for (int c = 0; c < NUM_CH; c++) begin
        logic [31:0] d;
        d = $urandom;
        bus.wr_valid[c] = 1'b1;
        bus.wr_op[c]    = MEM_WORD;
        bus.wr_addr[c*ADDR_W +: ADDR_W] = 8'(w * 4);
        bus.wr_data[c*32 +: 32] = d;
        model_store(c, 2'd2, 8'(w * 4), d);
      end
      tick();
    end
    bus.wr_valid = '0;
    tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_rdy;
    logic       exp_busy;
`ifdef VGA_RAM_CLEAR_EN
    exp_rdy = 4'h0; exp_busy = 1'b1;
`else
    exp_rdy = 4'hF; exp_busy = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (rd_data !== '0) $display("FAIL reset_rd_data: got %h required 0", rd_data);
    else n_pass++;
    n_chk++;
    if (bus.wr_ready !== exp_rdy) $display("FAIL reset_wr_ready: got %b required %b", bus.wr_ready, exp_rdy);
    else n_pass++;
    n_chk++;
    if (clear_busy !== exp_busy) $display("FAIL reset_clear_busy: got %b required %b", clear_busy, exp_busy);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_chk++;
    if (bus.wr_ready !== exp_rdy) $display("FAIL post_reset_wr_ready: got %b required %b", bus.wr_ready, exp_rdy);
    else n_pass++;
  endtask

`ifdef VGA_RAM_CLEAR_EN
  task automatic test_clear();
    int cnt;
    prefill();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (clear_busy === 1'b1 && cnt < 200) begin
      n_chk++;
      if (bus.wr_ready !== 4'h0) $display("FAIL clear_wr_ready cycle %0d: got %b required 0000", cnt, bus.wr_ready);
      else n_pass++;
      cnt++;
      tick();
    end
    n_chk++;
    if (cnt != DEPTH) $display("FAIL clear_busy_cycles: got %0d required %0d", cnt, DEPTH);
    else n_pass++;
    n_chk++;
    if (bus.wr_ready !== 4'hF) $display("FAIL clear_done_wr_ready: got %b required 1111", bus.wr_ready);
    else n_pass++;
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < 256; b++) ref_mem[c][b] = 8'h00;
    check_all("clear_zero");
  endtask
`endif

  task automatic test_aligned();
    wait_ready(0);
    bus.wr_valid[0] = 1'b1;
    bus.wr_op[0]    = MEM_WORD;
    bus.wr_addr[0 +: ADDR_W] = 8'h08;
    bus.wr_data[0 +: 32] = 32'hDEADBEEF;
    tick();
    bus.wr_valid[0] = 1'b0;
    model_store(0, 2'd2, 8'h08, 32'hDEADBEEF);
    rd_addr = 6'd2;
    tick();
    n_chk++;
    if (rd_data[0 +: 32] !== 32'hDEADBEEF) $display("FAIL aligned_word: got %h required deadbeef", rd_data[0 +: 32]);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    do_write(3, 2'd2, 8'h00, 32'h0);
    do_write(3, 2'd0, 8'h03, 32'hFFFF_FFAB);
    read_word(0);
    n_chk++;
    if (rd_data[96 +: 32] !== 32'hAB000000) $display("FAIL byte_lanes: got %h required ab000000", rd_data[96 +: 32]);
    else n_pass++;
  endtask

  task automatic test_split_half();
    wait_ready(1);
    bus.wr_valid[1] = 1'b1;
    bus.wr_op[1]    = MEM_HALF_WORD;
    bus.wr_addr[ADDR_W +: ADDR_W] = 8'h07;
    bus.wr_data[32 +: 32] = 32'h0000_1234;
    tick();
    bus.wr_valid[1] = 1'b0;
    model_store(1, 2'd1, 8'h07, 32'h1234);
    n_chk++;
    if (bus.wr_ready[1] !== 1'b0) $display("FAIL split_ready_low: got %b required 0", bus.wr_ready[1]);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.wr_ready[1] !== 1'b1) $display("FAIL split_ready_back: got %b required 1", bus.wr_ready[1]);
    else n_pass++;
    read_word(1);
    n_chk++;
    if (rd_data[32 +: 32] !== ref_word(1, 1) || rd_data[56 +: 8] !== 8'h34)
      $display("FAIL split_word1: got %h required %h", rd_data[32 +: 32], ref_word(1, 1));
    else n_pass++;
    read_word(2);
    n_chk++;
    if (rd_data[32 +: 32] !== ref_word(1, 2) || rd_data[32 +: 8] !== 8'h12)
      $display("FAIL split_word2: got %h required %h", rd_data[32 +: 32], ref_word(1, 2));
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_write(2, 2'd2, 8'hFE, 32'h11223344);
    read_word(63);
    n_chk++;
    if (rd_data[64 +: 32] !== ref_word(2, 63) || rd_data[80 +: 16] !== 16'h3344)
      $display("FAIL wrap_word63: got %h required %h", rd_data[64 +: 32], ref_word(2, 63));
    else n_pass++;
    read_word(0);
    n_chk++;
    if (rd_data[64 +: 32] !== ref_word(2, 0) || rd_data[64 +: 16] !== 16'h1122)
      $display("FAIL wrap_word0: got %h required %h", rd_data[64 +: 32], ref_word(2, 0));
    else n_pass++;
  endtask

  task automatic test_parallel_read_first();
    logic [31:0] old_w [NUM_CH];
    logic [31:0] new_w [NUM_CH];
    read_word(5);
    for (int c = 0; c < NUM_CH; c++) begin
      wait_ready(c);
      old_w[c] = ref_word(c, 5);
      new_w[c] = $urandom;
      bus.wr_valid[c] = 1'b1;
      bus.wr_op[c]    = MEM_WORD;
      bus.wr_addr[c*ADDR_W +: ADDR_W] = 8'h14;
      bus.wr_data[c*32 +: 32] = new_w[c];
    end
    tick();
    bus.wr_valid = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      model_store(c, 2'd2, 8'h14, new_w[c]);
      n_chk++;
      if (rd_data[c*32 +: 32] !== old_w[c])
        $display("FAIL read_first_old ch%0d: got %h required %h", c, rd_data[c*32 +: 32], old_w[c]);
      else n_pass++;
    end
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      n_chk++;
      if (rd_data[c*32 +: 32] !== new_w[c])
        $display("FAIL read_first_new ch%0d: got %h required %h", c, rd_data[c*32 +: 32], new_w[c]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] exp_rdy;
    logic [NUM_CH-1:0] acc;
    logic [1:0]        op   [NUM_CH];
    logic [7:0]        addr [NUM_CH];
    logic [31:0]       data [NUM_CH];
    tick();
    exp_rdy = '1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        n_chk++;
        if (bus.wr_ready[c] !== exp_rdy[c])
          $display("FAIL random_ready cyc%0d ch%0d: got %b required %b", cyc, c, bus.wr_ready[c], exp_rdy[c]);
        else n_pass++;
        op[c]   = 2'($urandom_range(0, 3));
        addr[c] = 8'($urandom);
        data[c] = $urandom;
        bus.wr_valid[c] = 1'($urandom_range(0, 1));
        bus.wr_op[c]    = mem_op_t'(op[c]);
        bus.wr_addr[c*ADDR_W +: ADDR_W] = addr[c];
        bus.wr_data[c*32 +: 32] = data[c];
        acc[c] = bus.wr_valid[c] & exp_rdy[c];
      end
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        if (acc[c]) begin
          model_store(c, op[c], addr[c], data[c]);
          exp_rdy[c] = !crosses(op[c], addr[c]);
        end else begin
          exp_rdy[c] = 1'b1;
        end
      end
    end
    bus.wr_valid = '0;
    tick();
    check_all("random_contents");
  endtask

`ifndef VGA_RAM_CLEAR_EN
  task automatic test_reset_mid_split();
    wait_ready(0);
    bus.wr_valid[0] = 1'b1;
    bus.wr_op[0]    = MEM_WORD;
    bus.wr_addr[0 +: ADDR_W] = 8'h1E;
    bus.wr_data[0 +: 32] = 32'hA1B2C3D4;
    tick();
    bus.wr_valid[0] = 1'b0;
    // Only beat 1 survives: bytes 0x1E, 0x1F.
    model_store(0, 2'd1, 8'h1E, 32'h0000C3D4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (bus.wr_ready[0] !== 1'b1) $display("FAIL mid_split_ready: got %b required 1", bus.wr_ready[0]);
    else n_pass++;
    read_word(7);
    n_chk++;
    if (rd_data[0 +: 32] !== ref_word(0, 7)) $display("FAIL mid_split_word7: got %h required %h", rd_data[0 +: 32], ref_word(0, 7));
    else n_pass++;
    read_word(8);
    n_chk++;
    if (rd_data[0 +: 32] !== ref_word(0, 8)) $display("FAIL mid_split_word8: got %h required %h", rd_data[0 +: 32], ref_word(0, 8));
    else n_pass++;
  endtask
`endif

  initial begin
    bus.wr_valid = '0;
    bus.wr_op    = {NUM_CH{MEM_WORD}};
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    test_reset();
`ifdef VGA_RAM_CLEAR_EN
    test_clear();
`endif
    prefill();
    test_aligned();
    test_byte_lanes();
    test_split_half();
    test_wrap();
    test_parallel_read_first();
    test_random();
`ifndef VGA_RAM_CLEAR_EN
    test_reset_mid_split();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
